// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/step controller: mode and state encodings.
// Default widths live here so the top and the bench agree on them.
package run_ctrl_pkg;

   localparam int CNT_W_DEF      = 32;
   localparam int DIV_W_DEF      = 8;
   localparam int PC_W_DEF       = 32;
   localparam int RST_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      MODE_HALT  = 2'd0,
      MODE_FREE  = 2'd1,
      MODE_STEP  = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      S_RST_HOLD = 3'd0,
      S_IDLE     = 3'd1,
      S_RUN      = 3'd2,
      S_BURST    = 3'd3,
      S_BREAK    = 3'd4
   } state_e;

endpackage

// File: rtl/run_prescaler.sv
// Enable prescaler: ticks once every div_i+1 enabled cycles.
// Held at zero while cleared so the first tick after entry is deterministic.
module run_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;

   // >= keeps the divider from running a full wrap if div_i shrinks mid-run
   assign tick_o = en_i && (cnt_q >= div_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i || tick_o) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer driving the core reset and one-cycle clock enable.
// Define RUN_CTRL_BKPT_EN to build the PC breakpoint and BREAK state.
import run_ctrl_pkg::*;

module cpu_run_ctrl #(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int PC_W       = PC_W_DEF,
   parameter int RST_CYCLES = RST_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_i,
   input  logic             start_i,
   input  logic             step_i,
   input  logic             sw_rst_i,
   input  logic [CNT_W-1:0] burst_len_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [PC_W-1:0]  pc_i,
   input  logic [PC_W-1:0]  bkpt_pc_i,
   input  logic             bkpt_en_i,
   output logic             cpu_rst_o,
   output logic             cpu_ce_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             bkpt_hit_o
);

   localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_e           state_q, state_n;
   mode_e            mode;
   logic [HW-1:0]    hold_q, hold_n;
   logic [CNT_W-1:0] rem_q, rem_n;
   logic [CNT_W-1:0] cnt_q;
   logic             ce_q, ce_n;
   logic             done_q, done_n;
   logic             start_q, step_q;
   logic             start_edge, step_edge;
   logic             step_fire_q, step_fire_n;
   logic             pre_en, tick;

`ifdef RUN_CTRL_BKPT_EN
   logic ret_burst_q, ret_burst_n;
   logic skip_q, skip_n;
   logic bkpt_match;
   assign bkpt_match = bkpt_en_i && (pc_i == bkpt_pc_i) && !skip_q;
`else
   logic unused_bkpt;
   assign unused_bkpt = ^{pc_i, bkpt_pc_i, bkpt_en_i};
`endif

   assign mode       = mode_e'(mode_i);
   assign start_edge = start_i & ~start_q;
   assign step_edge  = step_i & ~step_q;
   assign pre_en     = (state_q == S_RUN) || (state_q == S_BURST);

   run_prescaler #(
      .DIV_W (DIV_W)
   ) u_pre (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (!pre_en),
      .en_i   (pre_en),
      .div_i  (div_i),
      .tick_o (tick)
   );

   always_comb begin
      state_n     = state_q;
      hold_n      = hold_q;
      rem_n       = rem_q;
      ce_n        = 1'b0;
      done_n      = 1'b0;
      step_fire_n = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
      ret_burst_n = ret_burst_q;
      skip_n      = skip_q;
`endif
      if (sw_rst_i) begin
         state_n = S_RST_HOLD;
         hold_n  = '0;
         rem_n   = '0;
      end else begin
         unique case (state_q)
            S_RST_HOLD: begin
               if (hold_q == HW'(RST_CYCLES - 1)) begin
                  state_n = S_IDLE;
                  hold_n  = '0;
               end else begin
                  hold_n = hold_q + 1'b1;
               end
            end
            S_IDLE: begin
               // step edge was registered last cycle; fire its enable now
               ce_n = step_fire_q;
               if (mode == MODE_FREE && start_edge) begin
                  state_n = S_RUN;
               end else if (mode == MODE_BURST && start_edge) begin
                  if (burst_len_i == '0) begin
                     done_n = 1'b1;
                  end else begin
                     rem_n   = burst_len_i;
                     state_n = S_BURST;
                  end
               end else if (mode == MODE_STEP && step_edge) begin
                  step_fire_n = 1'b1;
               end
            end
            S_RUN: begin
               if (mode != MODE_FREE) begin
                  state_n = S_IDLE;
               end else if (tick) begin
`ifdef RUN_CTRL_BKPT_EN
                  if (bkpt_match) begin
                     state_n     = S_BREAK;
                     ret_burst_n = 1'b0;
                  end else begin
                     ce_n   = 1'b1;
                     skip_n = 1'b0;
                  end
`else
                  ce_n = 1'b1;
`endif
               end
            end
            S_BURST: begin
               if (mode != MODE_BURST) begin
                  state_n = S_IDLE;
               end else if (tick) begin
`ifdef RUN_CTRL_BKPT_EN
                  if (bkpt_match) begin
                     state_n     = S_BREAK;
                     ret_burst_n = 1'b1;
                  end else begin
                     skip_n = 1'b0;
`endif
                     ce_n  = 1'b1;
                     rem_n = rem_q - 1'b1;
                     if (rem_q == CNT_W'(1)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                     end
`ifdef RUN_CTRL_BKPT_EN
                  end
`endif
               end
            end
`ifdef RUN_CTRL_BKPT_EN
            S_BREAK: begin
               if (start_edge) begin
                  state_n = ret_burst_q ? S_BURST : S_RUN;
                  skip_n  = 1'b1;
               end
            end
`endif
            default: begin
               state_n = S_RST_HOLD;
               hold_n  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_RST_HOLD;
         hold_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         ce_q        <= 1'b0;
         done_q      <= 1'b0;
         start_q     <= 1'b0;
         step_q      <= 1'b0;
         step_fire_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         hold_q      <= hold_n;
         rem_q       <= rem_n;
         ce_q        <= ce_n;
         done_q      <= done_n;
         start_q     <= start_i;
         step_q      <= step_i;
         step_fire_q <= step_fire_n;
         if (sw_rst_i || state_q == S_RST_HOLD) begin
            cnt_q <= '0;
         end else if (ce_n && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

`ifdef RUN_CTRL_BKPT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ret_burst_q <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         ret_burst_q <= ret_burst_n;
         skip_q      <= skip_n;
      end
   end
   assign bkpt_hit_o = (state_q == S_BREAK);
`else
   assign bkpt_hit_o = 1'b0;
`endif

   assign cpu_rst_o   = (state_q == S_RST_HOLD);
   assign cpu_ce_o    = ce_q;
   assign cycle_cnt_o = cnt_q;
   assign busy_o      = pre_en;
   assign done_o      = done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: per-cycle vector table plus
// hand sequences for soft/async reset and the breakpoint path.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  mode_i = 2'd0;
   logic        start_i = 1'b0;
   logic        step_i = 1'b0;
   logic        sw_rst_i = 1'b0;
   logic [31:0] burst_len_i = '0;
   logic [7:0]  div_i = '0;
   logic [31:0] pc_i;
   logic [31:0] bkpt_pc_i = '0;
   logic        bkpt_en_i = 1'b0;
   logic        cpu_rst_o, cpu_ce_o, busy_o, done_o, bkpt_hit_o;
   logic [31:0] cycle_cnt_o;

   int n_vec  = 0;
   int n_fail = 0;
   int n_done = 0;

   cpu_run_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .mode_i      (mode_i),
      .start_i     (start_i),
      .step_i      (step_i),
      .sw_rst_i    (sw_rst_i),
      .burst_len_i (burst_len_i),
      .div_i       (div_i),
      .pc_i        (pc_i),
      .bkpt_pc_i   (bkpt_pc_i),
      .bkpt_en_i   (bkpt_en_i),
      .cpu_rst_o   (cpu_rst_o),
      .cpu_ce_o    (cpu_ce_o),
      .cycle_cnt_o (cycle_cnt_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .bkpt_hit_o  (bkpt_hit_o)
   );

   always #5 clk = ~clk;

   // core PC model: 4-byte step per enabled cycle
   always @(posedge clk or negedge rst) begin
      if (!rst) pc_i <= '0;
      else if (cpu_rst_o) pc_i <= '0;
      else if (cpu_ce_o) pc_i <= pc_i + 32'd4;
   end

   always @(posedge clk) if (done_o) n_done++;

   always @(negedge clk) begin
      if (cpu_ce_o && cpu_rst_o) begin
         n_fail++;
         $display("FAIL ce_during_rst: ce=%0b rst=%0b required ce=0", cpu_ce_o, cpu_rst_o);
      end
   end

   typedef struct {
      logic [1:0]  mode;
      logic        start;
      logic        step;
      logic [31:0] len;
      logic [7:0]  div;
      logic        e_rst;
      logic        e_ce;
      logic        e_busy;
      logic        e_done;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic [1:0] m, input logic s, input logic st,
                               input logic [31:0] l, input logic [7:0] d,
                               input logic r, input logic ce, input logic b,
                               input logic dn, input logic [31:0] c);
      vec_t v;
      v.mode = m; v.start = s; v.step = st; v.len = l; v.div = d;
      v.e_rst = r; v.e_ce = ce; v.e_busy = b; v.e_done = dn; v.e_cnt = c;
      tv.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] outs();
      return {27'd0, cpu_rst_o, cpu_ce_o, busy_o, done_o, bkpt_hit_o, cycle_cnt_o};
   endfunction

   function automatic logic [63:0] pack(input logic r, input logic ce, input logic b,
                                        input logic dn, input logic [31:0] c);
      return {27'd0, r, ce, b, dn, 1'b0, c};
   endfunction

   int saved_done;

   initial begin
      // reset release and burst of 5
      add(0,0,0,5,0, 1,0,0,0,0);
      add(3,0,0,5,0, 0,0,0,0,0);
      add(3,1,0,5,0, 0,0,1,0,0);
      add(3,1,0,5,0, 0,1,1,0,1);
      add(3,1,0,5,0, 0,1,1,0,2);
      add(3,1,0,5,0, 0,1,1,0,3);
      add(3,1,0,5,0, 0,1,1,0,4);
      add(3,1,0,5,0, 0,1,0,1,5);
      add(3,1,0,5,0, 0,0,0,0,5);
      // zero-length burst
      add(3,0,0,0,0, 0,0,0,0,5);
      add(3,1,0,0,0, 0,0,0,1,5);
      add(3,1,0,0,0, 0,0,0,0,5);
      // free run, div 3, halted where a tick was due
      add(1,0,0,0,3, 0,0,0,0,5);
      add(1,1,0,0,3, 0,0,1,0,5);
      add(1,1,0,0,3, 0,0,1,0,5);
      add(1,1,0,0,3, 0,0,1,0,5);
      add(1,1,0,0,3, 0,0,1,0,5);
      add(1,1,0,0,3, 0,1,1,0,6);
      add(1,1,0,0,3, 0,0,1,0,6);
      add(1,1,0,0,3, 0,0,1,0,6);
      add(1,1,0,0,3, 0,0,1,0,6);
      add(1,1,0,0,3, 0,1,1,0,7);
      add(1,1,0,0,3, 0,0,1,0,7);
      add(1,1,0,0,3, 0,0,1,0,7);
      add(1,1,0,0,3, 0,0,1,0,7);
      add(0,1,0,0,3, 0,0,0,0,7);
      add(0,1,0,0,3, 0,0,0,0,7);
      // step: three edges, one held two cycles
      add(2,0,0,0,0, 0,0,0,0,7);
      add(2,0,1,0,0, 0,0,0,0,7);
      add(2,0,0,0,0, 0,1,0,0,8);
      add(2,0,1,0,0, 0,0,0,0,8);
      add(2,0,1,0,0, 0,1,0,0,9);
      add(2,0,0,0,0, 0,0,0,0,9);
      add(2,0,1,0,0, 0,0,0,0,9);
      add(2,0,0,0,0, 0,1,0,0,10);
      add(2,0,0,0,0, 0,0,0,0,10);
      // edges in HALT are dropped, not queued
      add(0,1,1,0,0, 0,0,0,0,10);
      add(2,1,1,0,0, 0,0,0,0,10);
      add(2,1,1,0,0, 0,0,0,0,10);

      repeat (3) cyc();
      chk("in_reset", outs(), pack(1,0,0,0,0));
      rst = 1'b1;
      #1;
      chk("reset_release", outs(), pack(1,0,0,0,0));

      for (int i = 0; i < tv.size(); i++) begin
         mode_i = tv[i].mode; start_i = tv[i].start; step_i = tv[i].step;
         burst_len_i = tv[i].len; div_i = tv[i].div;
         cyc();
         chk($sformatf("row%0d", i), outs(),
             pack(tv[i].e_rst, tv[i].e_ce, tv[i].e_busy, tv[i].e_done, tv[i].e_cnt));
      end
      chk("done_pulses", 64'(n_done), 64'd2);

      // soft reset mid-burst
      saved_done = n_done;
      mode_i = 2'd3; burst_len_i = 32'd10; div_i = 8'd0; start_i = 1'b0; step_i = 1'b0;
      cyc();
      start_i = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("sw_burst_active", {62'd0, busy_o, cpu_ce_o}, 64'd3);
      sw_rst_i = 1'b1;
      cyc();
      chk("sw_rst_outs", outs(), pack(1,0,0,0,0));
      sw_rst_i = 1'b0;
      cyc();
      chk("sw_hold1", outs(), pack(1,0,0,0,0));
      cyc();
      chk("sw_hold2", outs(), pack(0,0,0,0,0));
      chk("sw_no_done", 64'(n_done), 64'(saved_done));

      // async reset mid-burst
      start_i = 1'b0;
      cyc();
      start_i = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("as_burst_active", {32'd0, 30'd0, busy_o, cpu_ce_o}, 64'd3);
      #2 rst = 1'b0;
      #1;
      chk("as_rst_immediate", outs(), pack(1,0,0,0,0));
      cyc();
      rst = 1'b1;
      cyc();
      chk("as_hold1", outs(), pack(1,0,0,0,0));
      cyc();
      chk("as_hold2", outs(), pack(0,0,0,0,0));
      cyc();
      chk("as_edge_dropped", outs(), pack(0,0,0,0,0));
      chk("as_no_done", 64'(n_done), 64'(saved_done));

      // breakpoint at 0x10, div 1 so the PC settles between ticks
      mode_i = 2'd1; div_i = 8'd1; start_i = 1'b0;
      bkpt_pc_i = 32'h10; bkpt_en_i = 1'b1;
      cyc();
      start_i = 1'b1;
`ifdef RUN_CTRL_BKPT_EN
      for (int i = 0; i < 100 && !bkpt_hit_o; i++) cyc();
      chk("bk_hit", 64'(bkpt_hit_o), 64'd1);
      chk("bk_pc", 64'(pc_i), 64'h10);
      chk("bk_cnt", 64'(cycle_cnt_o), 64'd4);
      repeat (3) cyc();
      chk("bk_hold", {31'd0, bkpt_hit_o, pc_i}, {31'd0, 1'b1, 32'h10});
      start_i = 1'b0;
      cyc();
      start_i = 1'b1;
      for (int i = 0; i < 20 && pc_i != 32'h14; i++) cyc();
      chk("bk_resume_pc", 64'(pc_i), 64'h14);
      chk("bk_resume_flag", 64'(bkpt_hit_o), 64'd0);
      chk("bk_resume_cnt", 64'(cycle_cnt_o), 64'd5);
`else
      for (int i = 0; i < 100 && pc_i != 32'h14; i++) cyc();
      chk("nbk_pc", 64'(pc_i), 64'h14);
      chk("nbk_flag", 64'(bkpt_hit_o), 64'd0);
      chk("nbk_cnt", 64'(cycle_cnt_o), 64'd5);
`endif
      mode_i = 2'd0;
      cyc();
      cyc();
      chk("halt_stop", {62'd0, busy_o, cpu_ce_o}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
